// File: rtl/asip_decode_pkg.sv
// Shared decode definitions: write-back source encodings, special opcodes,
// and the decoded control-bundle layout used by the decode stage.
package asip_decode_pkg;

  localparam logic [1:0] WRF_MEM = 2'b00;
  localparam logic [1:0] WRF_ALU = 2'b01;
  localparam logic [1:0] WRF_IMM = 2'b10;

  localparam logic [3:0] SUPIX = 4'hC;  // store pixel
  localparam logic [3:0] LOSC  = 4'h0;  // load scalar immediate

  typedef struct packed {
    logic       mem_write;
    logic [1:0] wrf;
    logic       wen_sc;
    logic       wen_vec;
  } dec_ctrl_t;

endpackage

// File: rtl/reg_scoreboard.sv
// Per-register write-back countdown; a register is busy while its count is nonzero.
// Latency: query is combinational, set/clear take effect at the next edge; no backpressure.
module reg_scoreboard #(
  parameter int RW     = 4,
  parameter int WB_LAT = 3
) (
  input  logic          clk,
  input  logic          clr_all,
  input  logic [RW-1:0] query_reg,
  output logic          query_busy,
  input  logic [RW-1:0] set_reg,
  input  logic          set_en
);

  localparam int NREG = 1 << RW;

  logic [3:0] cnt [NREG];

  assign query_busy = (cnt[query_reg] != 4'd0);

  always_ff @(posedge clk) begin
    for (int i = 0; i < NREG; i++) begin
      if (clr_all)
        cnt[i] <= 4'd0;
      else if (set_en && (set_reg == RW'(i)))
        cnt[i] <= 4'(WB_LAT);
      else if (cnt[i] != 4'd0)
        cnt[i] <= cnt[i] - 4'd1;
    end
  end

endmodule

// File: rtl/decoder_pipe.sv
// Instruction decode stage with register-hazard scoreboard; 1-cycle latency.
// Backpressure: holds the bundle while out_ready is low; stalls input on hazard or flush.
module decoder_pipe
  import asip_decode_pkg::*;
#(
  parameter int N       = 16,
  parameter int OPW     = 4,
  parameter int RW      = 4,
  parameter int IMMW    = N - OPW - RW,
  parameter int SEL_BIT = 2,
  parameter int WB_LAT  = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic [N-1:0]    in_instr,
  output logic            in_ready,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            MemoryWrite,
  output logic [1:0]      WriteRegFrom,
  output logic [RW-1:0]   RegToWrite,
  output logic [IMMW-1:0] Immediate,
  output logic            RegWriteEnSc,
  output logic            RegWriteEnVec,
  output logic            hazard_stall
);

  logic [OPW-1:0]  op;
  logic [RW-1:0]   rg;
  logic [IMMW-1:0] imm;
  logic            wen;
  logic            busy;
  logic            accept;
  dec_ctrl_t       dec;
  dec_ctrl_t       ctrl_q;
  logic [RW-1:0]   rg_q;
  logic [IMMW-1:0] imm_q;

  assign op  = in_instr[N-1 -: OPW];
  assign rg  = in_instr[N-OPW-1 -: RW];
  assign imm = in_instr[IMMW-1:0];

  // Stores never write back, so SUPIX is excluded from the write-enable term.
  always_comb begin
    dec           = '0;
    dec.mem_write = (op == OPW'(SUPIX));
    dec.wrf       = (op == OPW'(LOSC)) ? WRF_IMM : {1'b0, ~op[OPW-1]};
    wen           = (~op[0] | (op[1] & op[2])) & ~dec.mem_write;
    dec.wen_sc    = wen & rg[SEL_BIT];
    dec.wen_vec   = wen & ~rg[SEL_BIT];
  end

  assign hazard_stall = in_valid & busy;
  assign in_ready     = ~hazard_stall & (~out_valid | out_ready) & ~flush;
  assign accept       = in_valid & in_ready;

  reg_scoreboard #(
    .RW     (RW),
    .WB_LAT (WB_LAT)
  ) u_sb (
    .clk        (clk),
    .clr_all    (rst),
    .query_reg  (rg),
    .query_busy (busy),
    .set_reg    (rg),
    .set_en     (accept & wen)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      ctrl_q    <= '0;
      rg_q      <= '0;
      imm_q     <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      ctrl_q    <= dec;
      rg_q      <= rg;
      imm_q     <= imm;
    end else if (flush || out_ready) begin
      out_valid <= 1'b0;
    end
  end

  assign MemoryWrite   = ctrl_q.mem_write;
  assign WriteRegFrom  = ctrl_q.wrf;
  assign RegWriteEnSc  = ctrl_q.wen_sc;
  assign RegWriteEnVec = ctrl_q.wen_vec;
  assign RegToWrite    = rg_q;
  assign Immediate     = imm_q;

endmodule

// File: tb/tb_decoder_pipe.sv
// Directed test of decoder_pipe: decode fields, hazard stall, backpressure, flush, reset.
module tb_decoder_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [15:0] in_instr;
  logic        in_ready;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic        MemoryWrite;
  logic [1:0]  WriteRegFrom;
  logic [3:0]  RegToWrite;
  logic [7:0]  Immediate;
  logic        RegWriteEnSc;
  logic        RegWriteEnVec;
  logic        hazard_stall;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  decoder_pipe dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_instr      (in_instr),
    .in_ready      (in_ready),
    .flush         (flush),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .MemoryWrite   (MemoryWrite),
    .WriteRegFrom  (WriteRegFrom),
    .RegToWrite    (RegToWrite),
    .Immediate     (Immediate),
    .RegWriteEnSc  (RegWriteEnSc),
    .RegWriteEnVec (RegWriteEnVec),
    .hazard_stall  (hazard_stall)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_bundle(input string tag, input logic mw, input logic [1:0] wrf,
                            input logic [3:0] rg, input logic [7:0] imm,
                            input logic sc, input logic vec);
    chk({tag, ".mw"},  MemoryWrite,   mw);
    chk({tag, ".wrf"}, WriteRegFrom,  wrf);
    chk({tag, ".reg"}, RegToWrite,    rg);
    chk({tag, ".imm"}, Immediate,     imm);
    chk({tag, ".sc"},  RegWriteEnSc,  sc);
    chk({tag, ".vec"}, RegWriteEnVec, vec);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_instr = 16'h0; flush = 1'b0; out_ready = 1'b1;
    step(); step();
    chk("rst.out_valid", out_valid, 1'b0);
    chk_bundle("rst", 1'b0, 2'b00, 4'h0, 8'h00, 1'b0, 1'b0);
    rst = 1'b0;

    // LOSC r4, #5
    in_valid = 1'b1; in_instr = 16'h0405;
    chk("losc.in_ready", in_ready, 1'b1);
    chk("losc.hazard", hazard_stall, 1'b0);
    step(); in_valid = 1'b0;
    chk("losc.out_valid", out_valid, 1'b1);
    chk_bundle("losc", 1'b0, 2'b10, 4'h4, 8'h05, 1'b1, 1'b0);
    step(); step(); step();

    // SUPIX r3
    in_valid = 1'b1; in_instr = 16'hC300;
    step(); in_valid = 1'b0;
    chk_bundle("supix", 1'b1, 2'b00, 4'h3, 8'h00, 1'b0, 1'b0);

    // ALU op 2 to vector rA
    in_valid = 1'b1; in_instr = 16'h2A12;
    step();
    chk_bundle("alu_vec", 1'b0, 2'b01, 4'hA, 8'h12, 1'b0, 1'b1);

    // op 9: no write-back, high opcode bit -> memory source
    in_instr = 16'h9755;
    step(); in_valid = 1'b0;
    chk_bundle("op9", 1'b0, 2'b00, 4'h7, 8'h55, 1'b0, 1'b0);
    step(); step(); step(); step();

    // Back-to-back writes to r4
    in_valid = 1'b1; in_instr = 16'h0405;
    chk("haz.first_ready", in_ready, 1'b1);
    step();
    in_instr = 16'h4412;
    for (int k = 1; k <= 3; k++) begin
      chk($sformatf("haz.stall%0d", k), hazard_stall, 1'b1);
      chk($sformatf("haz.ready%0d", k), in_ready, 1'b0);
      step();
    end
    chk("haz.free", hazard_stall, 1'b0);
    chk("haz.ready4", in_ready, 1'b1);
    step();
    chk("haz.out_valid", out_valid, 1'b1);
    chk_bundle("haz", 1'b0, 2'b01, 4'h4, 8'h12, 1'b1, 1'b0);

    // Backpressure: bundle held for 5 cycles, nothing accepted
    out_ready = 1'b0; in_instr = 16'h2312;
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("bp.ready%0d", k), in_ready, 1'b0);
      chk($sformatf("bp.valid%0d", k), out_valid, 1'b1);
      chk($sformatf("bp.imm%0d", k), Immediate, 8'h12);
      chk($sformatf("bp.reg%0d", k), RegToWrite, 4'h4);
      step();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    step();
    chk("bp.drain", out_valid, 1'b0);

    // Flush while a bundle is held, r4 pending
    in_valid = 1'b1; in_instr = 16'h0405;
    step();
    out_ready = 1'b0; flush = 1'b1;
    chk("fl.ready", in_ready, 1'b0);
    step(); flush = 1'b0;
    chk("fl.valid", out_valid, 1'b0);
    chk("fl.cnt2", hazard_stall, 1'b1);
    step();
    chk("fl.cnt1", hazard_stall, 1'b1);
    step();
    chk("fl.cnt0", hazard_stall, 1'b0);
    chk("fl.ready_after", in_ready, 1'b1);
    in_valid = 1'b0;
    step();

    // Reset with r4 pending and a held bundle
    in_valid = 1'b1; in_instr = 16'h0405;
    step(); in_valid = 1'b0;
    chk("rs.pre_valid", out_valid, 1'b1);
    rst = 1'b1;
    step(); rst = 1'b0;
    in_valid = 1'b1; in_instr = 16'h4412;
    chk("rs.valid", out_valid, 1'b0);
    chk("rs.hazard", hazard_stall, 1'b0);
    chk("rs.ready", in_ready, 1'b1);
    chk("rs.reg", RegToWrite, 4'h0);
    step(); in_valid = 1'b0;
    chk("rs.accept", out_valid, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
